broadcast_scheduler: RTL

BROADCAST_SCHEDULER -- requirements
Module: broadcast_scheduler

---
 rtl/broadcast_scheduler_if.sv | 45 ++++
 rtl/broadcast_scheduler.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/broadcast_scheduler_if.sv
// -----------------------------------------------------------------------------
// broadcast_scheduler_if
// Request/grant bundle between four requesters and the broadcast scheduler.
//
// Handshake: requester i raises req[i] together with its frame, port and line
// and holds all of them stable until grant[i] pulses. grant[i] is a one-cycle
// pulse meaning "frame latched". The requester may then drop req[i] or change
// its fields freely. A req[i] that is still high during its own grant pulse is
// not treated as a new request, because req is only sampled while the
// scheduler is idle.
//
// Signals:
//   req       [3:0]           requester i has a frame pending
//   req_data  [4*FRAME_W-1:0] frame of requester i at [i*FRAME_W +: FRAME_W]
//   req_port  [7:0]           destination port of requester i at [2i+1:2i]
//   req_line  [7:0]           destination line of requester i at [2i+1:2i]
//   grant     [3:0]           one-hot latch pulse back to the requesters
// -----------------------------------------------------------------------------
interface broadcast_scheduler_if #(
    parameter int FRAME_W = 8
);
    logic [3:0]           req;
    logic [4*FRAME_W-1:0] req_data;
    logic [7:0]           req_port;
    logic [7:0]           req_line;
    logic [3:0]           grant;

    // Requester side
    modport master (
        output req,
        output req_data,
        output req_port,
        output req_line,
        input  grant
    );

    // Scheduler side
    modport slave (
        input  req,
        input  req_data,
        input  req_port,
        input  req_line,
        output grant
    );
endinterface

// File: rtl/broadcast_scheduler.sv
// -----------------------------------------------------------------------------
// broadcast_scheduler
// Picks one of four requesters round-robin, latches its frame, port and line,
// and plays the frame out serially to a broadcaster: one SETUP cycle with the
// port enabled, FRAME_W SHIFT cycles MSB first, then one GAP cycle with the
// port disabled and a done pulse.
//
// Ports:
//   clk        sole clock, rising edge
//   rst        synchronous active-high reset
//   bus        request/grant bundle (slave side)
//   serOut     serial frame data to the broadcaster serIn
//   PB [0:3]   port-enable vector, at most one bit high (PB[port])
//   LB [1:0]   line-select code, 3 - line
//   busy       high in every state except IDLE
//   done       one-cycle pulse in the GAP cycle
//   state_dbg  current FSM state (0 IDLE, 1 SETUP, 2 SHIFT, 3 GAP)
//
// Every output is a register; the state register is exported as-is.
// -----------------------------------------------------------------------------
module broadcast_scheduler #(
    parameter int FRAME_W = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    broadcast_scheduler_if.slave  bus,
    output logic                  serOut,
    output logic [0:3]            PB,
    output logic [1:0]            LB,
    output logic                  busy,
    output logic                  done,
    output logic [1:0]            state_dbg
);

    localparam int CNT_W = (FRAME_W > 2) ? $clog2(FRAME_W) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(FRAME_W - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        SHIFT = 2'd2,
        GAP   = 2'd3
    } state_t;

    state_t               state;
    logic [1:0]           rr_ptr;
    logic [FRAME_W-1:0]   shreg;
    logic [CNT_W-1:0]     bit_cnt;

    // Arbitration result for the current IDLE cycle
    logic                 win_found;
    logic [1:0]           win_idx;
    logic [FRAME_W-1:0]   win_data;
    logic [1:0]           win_port;
    logic [1:0]           win_line;
    logic [0:3]           pb_dec;

    // Round-robin search: first pending requester at or above rr_ptr,
    // wrapping 3 -> 0. The 2-bit sum wraps naturally.
    always_comb begin
        win_found = 1'b0;
        win_idx   = rr_ptr;
        for (int k = 0; k < 4; k++) begin
            if (!win_found && bus.req[rr_ptr + 2'(k)]) begin
                win_found = 1'b1;
                win_idx   = rr_ptr + 2'(k);
            end
        end
    end

    // Winner's fields and the port-enable decode
    always_comb begin
        win_data = bus.req_data[win_idx*FRAME_W +: FRAME_W];
        win_port = bus.req_port[{win_idx, 1'b0} +: 2];
        win_line = bus.req_line[{win_idx, 1'b0} +: 2];
        pb_dec   = '0;
        pb_dec[win_port] = 1'b1;
    end

    assign state_dbg = state;

    always_ff @(posedge clk) begin
        if (rst) begin
            // Any frame in flight is dropped; nothing is kept for resumption.
            state     <= IDLE;
            rr_ptr    <= 2'd0;
            bus.grant <= 4'b0000;
            serOut    <= 1'b0;
            PB        <= 4'b0000;
            LB        <= 2'b00;
            busy      <= 1'b0;
            done      <= 1'b0;
            shreg     <= '0;
            bit_cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done   <= 1'b0;
                    serOut <= 1'b0;
                    if (win_found) begin
                        // Latch everything now so later input churn cannot
                        // reach the frame in flight.
                        shreg     <= win_data;
                        rr_ptr    <= win_idx + 2'd1;
                        bus.grant <= 4'b0001 << win_idx;
                        PB        <= pb_dec;
                        LB        <= 2'd3 - win_line;
                        busy      <= 1'b1;
                        state     <= SETUP;
                    end else begin
                        bus.grant <= 4'b0000;
                        PB        <= 4'b0000;
                        busy      <= 1'b0;
                    end
                end

                SETUP: begin
                    // First SHIFT cycle presents the MSB.
                    bus.grant <= 4'b0000;
                    serOut    <= shreg[FRAME_W-1];
                    shreg     <= {shreg[FRAME_W-2:0], 1'b0};
                    bit_cnt   <= '0;
                    state     <= SHIFT;
                end

                SHIFT: begin
                    if (bit_cnt == LAST_BIT) begin
                        // LSB has just been shown; close the port for GAP.
                        serOut <= 1'b0;
                        PB     <= 4'b0000;
                        done   <= 1'b1;
                        state  <= GAP;
                    end else begin
                        serOut  <= shreg[FRAME_W-1];
                        shreg   <= {shreg[FRAME_W-2:0], 1'b0};
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end

                GAP: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
